// File: rtl/lr35902_snd_pulse.sv
`default_nettype none
// ============================================================================
// Module      : lr35902_snd_pulse
// Description : Square-wave (pulse) voice for the LR35902 APU. Holds the
//               NRx0..NRx4 register fields and contains the frequency timer,
//               duty sequencer, length counter, volume envelope and an
//               optional frequency sweep unit (HAS_SWEEP).
// Ports       : clk, reset (async, active-low)
//               ce                 - 1 MHz enable strobe
//               len/swp/env_tick   - frame-sequencer strobes (coincident with ce)
//               wr_swp..wr_fhi     - NRx0..NRx4 write strobes, data on din
//               sample             - registered voice amplitude (0 when silent)
//               active             - channel-on status
//               dac_on             - DAC enable (env_init != 0 || env_inc)
// Revision    : 1.0 - initial release
// ============================================================================
module lr35902_snd_pulse #(
    parameter int FREQ_W    = 11,
    parameter int LEN_W     = 6,
    parameter int VOL_W     = 4,
    parameter int HAS_SWEEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             len_tick,
    input  logic             swp_tick,
    input  logic             env_tick,
    input  logic             wr_swp,
    input  logic             wr_len,
    input  logic             wr_env,
    input  logic             wr_flo,
    input  logic             wr_fhi,
    input  logic [7:0]       din,
    output logic [VOL_W-1:0] sample,
    output logic             active,
    output logic             dac_on
);

    localparam logic              c_HAS_SWEEP = (HAS_SWEEP != 0);
    localparam logic [FREQ_W-1:0] c_FREQ_MAX  = {FREQ_W{1'b1}};
    localparam logic [FREQ_W:0]   c_FREQ_LIM  = {1'b0, {FREQ_W{1'b1}}};
    localparam logic [LEN_W:0]    c_LEN_FULL  = {1'b1, {LEN_W{1'b0}}};
    localparam logic [VOL_W-1:0]  c_VOL_MAX   = {VOL_W{1'b1}};

    // Register fields
    logic [2:0]        r_swp_time;
    logic              r_swp_dec;
    logic [2:0]        r_swp_shift;
    logic [1:0]        r_duty;
    logic [LEN_W:0]    r_len_cnt;
    logic [VOL_W-1:0]  r_env_init;
    logic              r_env_inc;
    logic [2:0]        r_env_time;
    logic [FREQ_W-1:0] r_freq;
    logic              r_cntlen;

    // Running state
    logic [FREQ_W-1:0] r_freq_cnt;
    logic [2:0]        r_duty_pos;
    logic [VOL_W-1:0]  r_vol;
    logic [2:0]        r_env_cnt;
    logic [FREQ_W-1:0] r_shadow;
    logic [3:0]        r_swp_cnt;
    logic              r_swp_en;
    logic              r_ovf_pend;
    logic              r_active;
    logic [VOL_W-1:0]  r_sample;

    // Post-write views of the register fields, so a trigger in the same
    // cycle as other writes sees the freshly written values.
    logic [2:0]        w_swp_time;
    logic              w_swp_dec;
    logic [2:0]        w_swp_shift;
    logic [1:0]        w_duty;
    logic [LEN_W:0]    w_len_cnt;
    logic [VOL_W-1:0]  w_env_init;
    logic              w_env_inc;
    logic [2:0]        w_env_time;
    logic              w_dac_on;
    logic [FREQ_W-1:0] w_freq;
    logic              w_trig;
    logic              w_trig_ovf;
    logic [FREQ_W:0]   w_swp_new;
    logic              w_swp_ovf;
    logic              w_swp_ovf2;
    logic [7:0]        w_pattern;
    logic              w_pat_bit;

    function automatic logic [FREQ_W:0] f_sweep(input logic [FREQ_W-1:0] base,
                                                input logic [2:0]        sh,
                                                input logic              dec);
        logic [FREQ_W:0] b;
        b = {1'b0, base};
        f_sweep = dec ? (b - (b >> sh)) : (b + (b >> sh));
    endfunction

    assign w_swp_time  = (c_HAS_SWEEP && wr_swp) ? din[6:4] : r_swp_time;
    assign w_swp_dec   = (c_HAS_SWEEP && wr_swp) ? din[3]   : r_swp_dec;
    assign w_swp_shift = (c_HAS_SWEEP && wr_swp) ? din[2:0] : r_swp_shift;
    assign w_duty      = wr_len ? din[7:6] : r_duty;
    assign w_len_cnt   = wr_len ? (c_LEN_FULL - {1'b0, din[LEN_W-1:0]}) : r_len_cnt;
    assign w_env_init  = wr_env ? VOL_W'(din[7:4]) : r_env_init;
    assign w_env_inc   = wr_env ? din[3]   : r_env_inc;
    assign w_env_time  = wr_env ? din[2:0] : r_env_time;
    assign w_dac_on    = (w_env_init != '0) || w_env_inc;
    assign w_freq[7:0]        = wr_flo ? din : r_freq[7:0];
    assign w_freq[FREQ_W-1:8] = wr_fhi ? din[FREQ_W-9:0] : r_freq[FREQ_W-1:8];
    assign w_trig      = wr_fhi && din[7];

    // Trigger-time overflow check on the new shadow (increase mode only).
    assign w_trig_ovf  = c_HAS_SWEEP && (w_swp_shift != 3'd0) && !w_swp_dec &&
                         (({1'b0, w_freq} + ({1'b0, w_freq} >> w_swp_shift)) > c_FREQ_LIM);

    // Sweep step and the look-ahead check on the value just written.
    assign w_swp_new   = f_sweep(r_shadow, r_swp_shift, r_swp_dec);
    assign w_swp_ovf   = !r_swp_dec && w_swp_new[FREQ_W];
    assign w_swp_ovf2  = !r_swp_dec &&
                         (({1'b0, w_swp_new[FREQ_W-1:0]} +
                           ({1'b0, w_swp_new[FREQ_W-1:0]} >> r_swp_shift)) > c_FREQ_LIM);

    // Duty patterns; bit index = duty_pos (position 0 is the first step).
    always_comb begin
        w_pattern = 8'b1000_0000;
        case (r_duty)
            2'd0:    w_pattern = 8'b1000_0000;
            2'd1:    w_pattern = 8'b1000_0001;
            2'd2:    w_pattern = 8'b1110_0001;
            default: w_pattern = 8'b0111_1110;
        endcase
    end
    assign w_pat_bit = w_pattern[r_duty_pos];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_swp_time  <= '0;
            r_swp_dec   <= 1'b0;
            r_swp_shift <= '0;
            r_duty      <= '0;
            r_len_cnt   <= '0;
            r_env_init  <= '0;
            r_env_inc   <= 1'b0;
            r_env_time  <= '0;
            r_freq      <= '0;
            r_cntlen    <= 1'b0;
            r_freq_cnt  <= '0;
            r_duty_pos  <= '0;
            r_vol       <= '0;
            r_env_cnt   <= '0;
            r_shadow    <= '0;
            r_swp_cnt   <= '0;
            r_swp_en    <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_active    <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_swp_time  <= w_swp_time;
            r_swp_dec   <= w_swp_dec;
            r_swp_shift <= w_swp_shift;
            r_duty      <= w_duty;
            r_len_cnt   <= w_len_cnt;
            r_env_init  <= w_env_init;
            r_env_inc   <= w_env_inc;
            r_env_time  <= w_env_time;
            r_freq      <= w_freq;
            if (wr_fhi) begin
                r_cntlen <= din[6];
            end
            r_ovf_pend <= 1'b0;

            // Turning the DAC off kills the channel immediately.
            if (wr_env && !w_dac_on) begin
                r_active <= 1'b0;
            end
            if (r_ovf_pend) begin
                r_active <= 1'b0;
            end

            if (w_trig) begin
                // Trigger wins over any tick arriving in the same cycle.
                r_active   <= w_dac_on;
                r_freq_cnt <= w_freq;
                r_duty_pos <= '0;
                r_vol      <= w_env_init;
                r_env_cnt  <= w_env_time;
                if (w_len_cnt == '0) begin
                    r_len_cnt <= c_LEN_FULL;
                end
                r_shadow   <= w_freq;
                r_swp_cnt  <= (w_swp_time == 3'd0) ? 4'd8 : {1'b0, w_swp_time};
                r_swp_en   <= c_HAS_SWEEP && ((w_swp_time != 3'd0) || (w_swp_shift != 3'd0));
                r_ovf_pend <= w_trig_ovf;
            end else begin
                if (ce && r_active) begin
                    if (r_freq_cnt == c_FREQ_MAX) begin
                        r_freq_cnt <= r_freq;
                        r_duty_pos <= r_duty_pos + 3'd1;
                    end else begin
                        r_freq_cnt <= r_freq_cnt + 1'b1;
                    end
                end

                if (len_tick && r_cntlen && (r_len_cnt != '0) && !wr_len) begin
                    r_len_cnt <= r_len_cnt - 1'b1;
                    if (r_len_cnt == (LEN_W+1)'(1)) begin
                        r_active <= 1'b0;
                    end
                end

                if (env_tick && (r_env_time != 3'd0) && r_active) begin
                    // A zero counter (env_time raised after trigger) reloads too.
                    if (r_env_cnt <= 3'd1) begin
                        r_env_cnt <= r_env_time;
                        if (r_env_inc && (r_vol != c_VOL_MAX)) begin
                            r_vol <= r_vol + 1'b1;
                        end else if (!r_env_inc && (r_vol != '0)) begin
                            r_vol <= r_vol - 1'b1;
                        end
                    end else begin
                        r_env_cnt <= r_env_cnt - 3'd1;
                    end
                end

                if (c_HAS_SWEEP && swp_tick) begin
                    if (r_swp_cnt <= 4'd1) begin
                        r_swp_cnt <= (r_swp_time == 3'd0) ? 4'd8 : {1'b0, r_swp_time};
                        if (r_swp_en && (r_swp_time != 3'd0)) begin
                            if (w_swp_ovf) begin
                                r_active <= 1'b0;
                            end else if (r_swp_shift != 3'd0) begin
                                r_shadow <= w_swp_new[FREQ_W-1:0];
                                r_freq   <= w_swp_new[FREQ_W-1:0];
                                if (w_swp_ovf2) begin
                                    r_active <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        r_swp_cnt <= r_swp_cnt - 4'd1;
                    end
                end
            end

            r_sample <= (r_active && w_pat_bit) ? r_vol : '0;
        end
    end

    assign sample = r_sample;
    assign active = r_active;
    assign dac_on = (r_env_init != '0) || r_env_inc;

endmodule
`default_nettype wire
